sb_tx_clk_burst_ctrl: RTL and testbench
=======================================

SB_TX_CLK_BURST_CTRL -- requirements
Module: sb_tx_clk_burst_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: PLL cycles per sideband bit-time.
REQ-002 SHALL have parameter BURST_BITS, default 64: bit-times per clocked burst.
REQ-003 SHALL have parameter GAP_BITS, default 32: minimum gated-off bit-times between bursts.
REQ-004 SHALL have port i_pll_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_enable, input, 1: new grants allowed when high.
REQ-007 SHALL have port i_req, input, 2: burst request per requester (bit0 message encoder, bit1 pattern generator); level, held until granted.
REQ-008 SHALL have port o_gnt, output, 2: one-hot grant, registered.
REQ-009 SHALL have port o_ser_load, output, 1: one-cycle pulse telling the granted serializer to load its 64-bit word.
REQ-010 SHALL have port o_clk_gate_en, output, 1: enables the divided sideband clock to the pad.
REQ-011 SHALL have port o_bit_tick, output, 1: one-cycle pulse on the last PLL cycle of every bit-time.
REQ-012 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL run a free-running phase counter 0..DIV-1; o_bit_tick high when phase == DIV-1.
REQ-014 SHALL implement states IDLE, ALIGN, BURST, GAP.
REQ-015 IDLE: if i_enable and any i_req, SHALL register a one-hot o_gnt and move to ALIGN on the next edge; otherwise stay.
REQ-016 Arbitration SHALL be round-robin: with both requests pending, grant the requester not granted last; after reset, requester 0 has priority.
REQ-017 ALIGN: on the cycle o_bit_tick is high, SHALL move to BURST; BURST therefore always starts at phase 0.
REQ-018 o_ser_load SHALL be high for exactly the first cycle of BURST.
REQ-019 o_clk_gate_en SHALL be high for every cycle of BURST and low in all other states: exactly BURST_BITS*DIV cycles (256 by default).
REQ-020 BURST SHALL count bit ticks; on the BURST_BITS-th tick it SHALL move to GAP and clear o_gnt on the same edge.
REQ-021 GAP SHALL last exactly GAP_BITS*DIV cycles (128 by default), then move to IDLE.
REQ-022 A new grant SHALL not be issued before IDLE is reached; the minimum request-to-request spacing is guaranteed by REQ-021.
REQ-023 Deassertion of the granted i_req during ALIGN or BURST SHALL NOT abort; the burst completes in full.
REQ-024 i_enable low SHALL only block new grants in IDLE; an in-flight ALIGN/BURST/GAP completes.
REQ-025 Bit counters SHALL be sized clog2(max(BURST_BITS,GAP_BITS)+1) and SHALL never wrap within a state.
REQ-026 o_gnt SHALL never have both bits set.

Reset
REQ-027 On i_rst_n low, immediately and without clock, SHALL force state IDLE, phase 0, counters 0, round-robin pointer to requester 0; o_gnt = 0, o_ser_load = 0, o_clk_gate_en = 0, o_busy = 0; o_bit_tick is low while reset is asserted.
REQ-028 Reset asserted mid-BURST SHALL drop o_clk_gate_en in the same instant; after release the block starts from IDLE with no pending-grant memory.
REQ-029 After release, the first o_bit_tick SHALL occur DIV cycles later.

Structure
REQ-030 Package sb_pkg SHALL hold the state enum and the default values of DIV, BURST_BITS and GAP_BITS.
REQ-031 The phase counter and o_bit_tick generation SHALL be a sub-module sb_phase_counter; arbitration and the FSM stay in the top module.

Verification
REQ-032 Scenario: i_req=01 held with i_enable=1 -> o_gnt=01 one cycle later, o_ser_load pulse once, o_clk_gate_en high exactly 256 cycles, then 128 cycles low, then o_busy=0.
REQ-033 Scenario: i_req=11 from reset, held -> grant order 01, 10, 01, with each burst separated by at least 128 gated cycles.
REQ-034 Scenario: i_req=01 dropped 10 cycles into BURST -> burst still 256 cycles, o_gnt cleared at the BURST-to-GAP edge.
REQ-035 Scenario: i_rst_n pulsed low 100 cycles into BURST -> all outputs 0 asynchronously; after release with i_req=10 -> o_gnt=10 and normal burst.
REQ-036 Scenario: i_enable low with i_req=10 -> no grant, o_busy=0; i_enable dropped during BURST -> burst and gap complete, no further grant.
REQ-037 Scenario: request raised at phase 1 -> BURST entry, and the o_ser_load pulse, on the cycle after the next o_bit_tick.

Source files
------------

// File: rtl/sb_tx_clk_burst_ctrl_pkg.sv
// Shared types and default timing parameters for the sideband TX clock burst controller.
package sb_pkg;

   localparam int unsigned DIV_DEFAULT        = 4;
   localparam int unsigned BURST_BITS_DEFAULT = 64;
   localparam int unsigned GAP_BITS_DEFAULT   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_BURST = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sb_tx_clk_burst_ctrl_phase_counter.sv
// Free-running bit-time phase counter; bit_tick_o marks the last PLL cycle of each bit-time.
module sb_phase_counter
   import sb_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic bit_tick_o
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   always_comb begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Qualified with reset so the tick stays low while reset is held, even for DIV == 1.
   assign bit_tick_o = rst_ni & (phase_q == PHASE_LAST);

endmodule

// File: rtl/sb_tx_clk_burst_ctrl.sv
// Round-robin arbiter and burst FSM that gates the divided sideband clock in
// bit-aligned bursts separated by a guaranteed idle gap.
module sb_tx_clk_burst_ctrl
   import sb_pkg::*;
#(
   parameter int unsigned DIV        = DIV_DEFAULT,
   parameter int unsigned BURST_BITS = BURST_BITS_DEFAULT,
   parameter int unsigned GAP_BITS   = GAP_BITS_DEFAULT
) (
   input  logic       i_pll_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output logic       o_ser_load,
   output logic       o_clk_gate_en,
   output logic       o_bit_tick,
   output logic       o_busy
);

   localparam int unsigned CW = $clog2(max_u(BURST_BITS, GAP_BITS) + 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_BITS - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_BITS - 1);

   state_e        state_q;
   logic [CW-1:0] bit_cnt_q;
   logic          rr_ptr_q;
   logic [1:0]    gnt_q;
   logic          load_q;
   logic          gate_q;
   logic          busy_q;

   logic          bit_tick;
   logic          grant_valid;
   logic          grant_idx;
   logic [1:0]    gnt_d;

   sb_phase_counter #(
      .DIV (DIV)
   ) u_phase (
      .clk_i      (i_pll_clk),
      .rst_ni     (i_rst_n),
      .bit_tick_o (bit_tick)
   );

   // rr_ptr_q names the requester that wins a tie; a lone request always wins.
   always_comb begin
      grant_valid = i_enable && (i_req != 2'b00);
      grant_idx   = (i_req == 2'b11) ? rr_ptr_q : i_req[1];
      gnt_d       = grant_idx ? 2'b10 : 2'b01;
   end

   always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rr_ptr_q  <= 1'b0;
         gnt_q     <= 2'b00;
         load_q    <= 1'b0;
         gate_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         load_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  gnt_q    <= gnt_d;
                  rr_ptr_q <= ~grant_idx;
                  busy_q   <= 1'b1;
                  state_q  <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (bit_tick) begin
                  load_q    <= 1'b1;
                  gate_q    <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= ST_BURST;
               end
            end
            // Both BURST and GAP start at phase 0, so counting ticks gives whole bit-times.
            ST_BURST: begin
               if (bit_tick) begin
                  if (bit_cnt_q == BURST_LAST) begin
                     gate_q    <= 1'b0;
                     gnt_q     <= 2'b00;
                     bit_cnt_q <= '0;
                     state_q   <= ST_GAP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end
               end
            end
            ST_GAP: begin
               if (bit_tick) begin
                  if (bit_cnt_q == GAP_LAST) begin
                     busy_q    <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_gnt         = gnt_q;
   assign o_ser_load    = load_q;
   assign o_clk_gate_en = gate_q;
   assign o_bit_tick    = bit_tick;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_sb_tx_clk_burst_ctrl.sv
// Scoreboard bench: stimulus queues the expected burst, a negedge monitor checks each burst it sees.
module tb_sb_tx_clk_burst_ctrl;

   localparam int DIV       = 4;
   localparam int BURST_LEN = 256;
   localparam int GAP_LEN   = 128;

   typedef struct {
      logic [1:0] gnt;
      int         burstLen;
      int         gapLen;
      bit         abort;
      int         loadCyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] req;
   logic [1:0] o_gnt;
   logic       o_ser_load;
   logic       o_clk_gate_en;
   logic       o_bit_tick;
   logic       o_busy;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   ph = 0;
   int   monMode = 0;
   exp_t scoreQ[$];

   sb_tx_clk_burst_ctrl dut (
      .i_pll_clk     (clk),
      .i_rst_n       (rst_n),
      .i_enable      (enable),
      .i_req         (req),
      .o_gnt         (o_gnt),
      .o_ser_load    (o_ser_load),
      .o_clk_gate_en (o_clk_gate_en),
      .o_bit_tick    (o_bit_tick),
      .o_busy        (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference bit phase: reset to 0, advances once per PLL cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= 0;
      else        ph <= (ph + 1) % DIV;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] r);
      enable = en;
      req    = r;
   endtask

   function automatic exp_t mkRec(input logic [1:0] g, input int bl, input bit ab, input int lc);
      exp_t r;
      r.gnt      = g;
      r.burstLen = bl;
      r.gapLen   = GAP_LEN;
      r.abort    = ab;
      r.loadCyc  = lc;
      return r;
   endfunction

   // Cycles from a request seen in IDLE at phase p to the BURST entry cycle.
   function automatic int expLoadLat(input int p);
      return 2 + ((2 * DIV - 2 - p) % DIV);
   endfunction

   task automatic checkResetOutputs();
      checkOutput("reset gnt", 32'(o_gnt), 0);
      checkOutput("reset ser_load", 32'(o_ser_load), 0);
      checkOutput("reset clk_gate_en", 32'(o_clk_gate_en), 0);
      checkOutput("reset busy", 32'(o_busy), 0);
      checkOutput("reset bit_tick", 32'(o_bit_tick), 0);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      #1;
      checkResetOutputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitPop(input string name);
      int n = 0;
      while (scoreQ.size() != 0 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput(name, 32'(scoreQ.size()), 0);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(monMode == 0 && !o_busy) && n < 2000);
      checkOutput(name, 32'(o_busy), 0);
   endtask

   // Monitor: one expected record is consumed per o_ser_load pulse, then the burst and gap are timed.
   initial begin : monitor
      exp_t rec;
      int   gateCnt;
      int   gapCnt;
      int   loadCnt;
      bit   prevTick;
      rec      = mkRec(2'b00, BURST_LEN, 1'b0, -1);
      gateCnt  = 0;
      gapCnt   = 0;
      loadCnt  = 0;
      prevTick = 1'b0;
      forever begin
         @(negedge clk);
         checkOutput("bit tick", 32'(o_bit_tick), 32'(rst_n === 1'b1 && ph == DIV - 1));
         checkOutput("gnt one-hot", 32'(o_gnt != 2'b11), 1);
         if (monMode == 2) begin
            if (o_busy && !o_clk_gate_en) begin
               gapCnt++;
            end else begin
               checkOutput("gap length", gapCnt, rec.gapLen);
               checkOutput("busy after gap", 32'(o_busy), 0);
               monMode = 0;
            end
         end else if (monMode == 1) begin
            if (o_clk_gate_en) begin
               gateCnt++;
               if (o_ser_load) loadCnt++;
            end else begin
               checkOutput("burst length", gateCnt, rec.burstLen);
               checkOutput("load pulses", loadCnt, 1);
               checkOutput("gnt cleared at gap", 32'(o_gnt), 0);
               if (rec.abort) begin
                  monMode = 0;
               end else begin
                  checkOutput("busy in gap", 32'(o_busy), 1);
                  gapCnt  = 1;
                  monMode = 2;
               end
            end
         end
         if (monMode == 0) begin
            if (o_ser_load) begin
               checkOutput("burst expected", 32'(scoreQ.size() > 0), 1);
               if (scoreQ.size() > 0) rec = scoreQ.pop_front();
               else                   rec = mkRec(2'b00, BURST_LEN, 1'b0, -1);
               checkOutput("grant", 32'(o_gnt), 32'(rec.gnt));
               checkOutput("load after tick", 32'(prevTick), 1);
               checkOutput("gate at load", 32'(o_clk_gate_en), 1);
               if (rec.loadCyc >= 0) checkOutput("load cycle", cyc, rec.loadCyc);
               gateCnt = 1;
               loadCnt = 1;
               monMode = 1;
            end else begin
               checkOutput("gate outside burst", 32'(o_clk_gate_en), 0);
            end
         end
         prevTick = o_bit_tick;
      end
   end

   initial begin : stimulus
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'b00);
      #2;
      applyReset();

      // Single requester: grant next cycle, one full burst and gap.
      @(posedge clk);
      #1;
      scoreQ.push_back(mkRec(2'b01, BURST_LEN, 1'b0, cyc + expLoadLat(ph)));
      applyStimulus(1'b1, 2'b01);
      @(posedge clk);
      #1;
      checkOutput("grant latency", 32'(o_gnt), 32'(2'b01));
      checkOutput("busy after grant", 32'(o_busy), 1);
      waitPop("single burst started");
      applyStimulus(1'b1, 2'b00);
      waitIdle("single burst idle");

      // Both requesting from reset: 01, 10, 01.
      applyReset();
      scoreQ.push_back(mkRec(2'b01, BURST_LEN, 1'b0, -1));
      scoreQ.push_back(mkRec(2'b10, BURST_LEN, 1'b0, -1));
      scoreQ.push_back(mkRec(2'b01, BURST_LEN, 1'b0, -1));
      applyStimulus(1'b1, 2'b11);
      waitPop("round robin bursts");
      applyStimulus(1'b1, 2'b00);
      waitIdle("round robin idle");

      // Request dropped 10 cycles into the burst.
      scoreQ.push_back(mkRec(2'b01, BURST_LEN, 1'b0, -1));
      applyStimulus(1'b1, 2'b01);
      waitPop("drop-req burst started");
      repeat (10) @(negedge clk);
      applyStimulus(1'b1, 2'b00);
      waitIdle("drop-req idle");

      // Reset 100 cycles into a burst, then a fresh grant to requester 1.
      scoreQ.push_back(mkRec(2'b01, 100, 1'b1, -1));
      applyStimulus(1'b1, 2'b01);
      waitPop("reset burst started");
      repeat (99) @(negedge clk);
      #2;
      rst_n = 1'b0;
      applyStimulus(1'b1, 2'b10);
      #1;
      checkResetOutputs();
      scoreQ.push_back(mkRec(2'b10, BURST_LEN, 1'b0, -1));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("grant after reset", 32'(o_gnt), 32'(2'b10));
      waitPop("post-reset burst started");
      applyStimulus(1'b1, 2'b00);
      waitIdle("post-reset idle");

      // Enable low blocks grants; dropping it mid-burst lets the burst finish.
      applyStimulus(1'b0, 2'b10);
      repeat (20) @(negedge clk);
      #1;
      checkOutput("disabled gnt", 32'(o_gnt), 0);
      checkOutput("disabled busy", 32'(o_busy), 0);
      scoreQ.push_back(mkRec(2'b10, BURST_LEN, 1'b0, -1));
      applyStimulus(1'b1, 2'b10);
      waitPop("enable burst started");
      applyStimulus(1'b0, 2'b10);
      waitIdle("enable-drop idle");
      repeat (40) @(negedge clk);
      #1;
      checkOutput("no grant while disabled", 32'(o_gnt), 0);
      checkOutput("no busy while disabled", 32'(o_busy), 0);
      applyStimulus(1'b1, 2'b00);

      // Request raised at phase 1: BURST three cycles later.
      begin
         int n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (ph != 1 && n < 16);
         checkOutput("found phase 1", ph, 1);
      end
      scoreQ.push_back(mkRec(2'b01, BURST_LEN, 1'b0, cyc + 3));
      applyStimulus(1'b1, 2'b01);
      waitPop("phase-1 burst started");
      applyStimulus(1'b1, 2'b00);
      waitIdle("phase-1 idle");

      checkOutput("scoreboard drained", 32'(scoreQ.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
